// File: rtl/spi_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// spi_pkg : shared state type and code conversion for SPI converters
// Rev 1.0
// ------------------------------------------------------------------
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CONV     = 3'd1,
    CLK_HIGH = 3'd2,
    CLK_LOW  = 3'd3,
    DONE     = 3'd4
  } adc_state_t;

  localparam logic [31:0] OFFSET_MSB_MASK = 32'h8000_0000;

  // Flips bit (width-1) so an offset-binary code reads as two's complement.
  function automatic logic [31:0] offset_to_signed(input logic [31:0] word, input int width);
    return word ^ (OFFSET_MSB_MASK >> (32 - width));
  endfunction

endpackage
`default_nettype wire

// File: rtl/spi_phase_timer.sv
`default_nettype none
// ------------------------------------------------------------------
// spi_phase_timer : loadable down-counter, done while the count is zero
// Rev 1.0
// ------------------------------------------------------------------
module spi_phase_timer #(
  parameter int W = 3
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         done_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign done_o = (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/adc_reader.sv
`default_nettype none
// ------------------------------------------------------------------
// adc_reader : SPI master reading one ADC word per start request
// Rev 1.0
// ------------------------------------------------------------------
module adc_reader
  import spi_pkg::*;
#(
  parameter int DATA_W        = 16,
  parameter int CLK_DIV       = 1,
  parameter int CONV_CYCLES   = 4,
  parameter bit OFFSET_BINARY = 1'b1
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              start_i,
  output logic              is_idle_o,
  output logic [DATA_W-1:0] data_o,
  output logic              valid_o,
  output logic              spi_clk_o,
  input  logic              spi_miso_i,
  output logic              spi_cs_o
);

  localparam int CNT_MAX = (CLK_DIV > CONV_CYCLES) ? CLK_DIV : CONV_CYCLES;
  localparam int DIV_W   = $clog2(CNT_MAX + 1);
  localparam int BIT_W   = $clog2(DATA_W);

  localparam logic [DIV_W-1:0] CONV_LOAD = DIV_W'(CONV_CYCLES - 1);
  localparam logic [DIV_W-1:0] HALF_LOAD = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(DATA_W - 1);

  adc_state_t        state_q;
  logic              start_q;
  logic [BIT_W-1:0]  bit_cnt_q;
  logic [DATA_W-1:0] shift_q;
  logic [DATA_W-1:0] data_q;
  logic              cs_q;
  logic              sclk_q;
  logic              valid_q;
  logic              idle_q;

  logic              tmr_load;
  logic [DIV_W-1:0]  tmr_val;
  logic              tmr_done;
  logic [DATA_W-1:0] conv_word;

  spi_phase_timer #(.W(DIV_W)) u_timer (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .done_o     (tmr_done)
  );

  // Each phase reloads the timer on its final cycle for the phase that follows.
  always_comb begin
    tmr_load = 1'b1;
    tmr_val  = '0;
    case (state_q)
      IDLE:                    tmr_val = start_q ? CONV_LOAD : '0;
      CONV, CLK_HIGH, CLK_LOW: begin
        tmr_load = tmr_done;
        tmr_val  = HALF_LOAD;
      end
      default: ;
    endcase
  end

  generate
    if (OFFSET_BINARY) begin : g_offset
      assign conv_word = DATA_W'(offset_to_signed(32'(shift_q), DATA_W));
    end else begin : g_raw
      assign conv_word = shift_q;
    end
  endgenerate

  // start_i is registered before IDLE looks at it; DONE releases on the live level.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      start_q   <= 1'b0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      cs_q      <= 1'b1;
      sclk_q    <= 1'b0;
      valid_q   <= 1'b0;
      idle_q    <= 1'b1;
    end else begin
      start_q <= start_i;
      valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          bit_cnt_q <= LAST_BIT;
          if (start_q) begin
            state_q <= CONV;
            cs_q    <= 1'b0;
            idle_q  <= 1'b0;
          end
        end
        CONV: begin
          if (tmr_done) begin
            state_q <= CLK_HIGH;
            sclk_q  <= 1'b1;
          end
        end
        CLK_HIGH: begin
          if (tmr_done) begin
            shift_q <= {shift_q[DATA_W-2:0], spi_miso_i};
            state_q <= CLK_LOW;
            sclk_q  <= 1'b0;
          end
        end
        CLK_LOW: begin
          if (tmr_done) begin
            if (bit_cnt_q != '0) begin
              bit_cnt_q <= bit_cnt_q - 1'b1;
              state_q   <= CLK_HIGH;
              sclk_q    <= 1'b1;
            end else begin
              state_q <= DONE;
              cs_q    <= 1'b1;
              data_q  <= conv_word;
              valid_q <= 1'b1;
            end
          end
        end
        DONE: begin
          if (!start_i) begin
            state_q <= IDLE;
            idle_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          cs_q    <= 1'b1;
          sclk_q  <= 1'b0;
          idle_q  <= 1'b1;
        end
      endcase
    end
  end

  assign is_idle_o = idle_q;
  assign data_o    = data_q;
  assign valid_o   = valid_q;
  assign spi_clk_o = sclk_q;
  assign spi_cs_o  = cs_q;

endmodule
`default_nettype wire

// File: tb/tb_adc_reader.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_adc_reader : three adc_reader configurations against ADC slave models
// Rev 1.0
// ------------------------------------------------------------------
module tb_adc_reader;

  localparam int DW = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic start_a = 1'b0, start_b = 1'b0, start_c = 1'b0;
  logic miso_a = 1'b0, miso_b = 1'b0, miso_c = 1'b0;
  logic [DW-1:0] word_a = '0, word_b = '0, word_c = '0;
  logic [DW-1:0] data_a, data_b, data_c;
  logic valid_a, valid_b, valid_c;
  logic idle_a, idle_b, idle_c;
  logic sclk_a, sclk_b, sclk_c;
  logic cs_a, cs_b, cs_c;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  adc_reader #(.DATA_W(DW), .CLK_DIV(1), .CONV_CYCLES(4), .OFFSET_BINARY(1'b1)) u_a (
    .clk_i(clk), .reset_i(rst), .start_i(start_a), .is_idle_o(idle_a), .data_o(data_a),
    .valid_o(valid_a), .spi_clk_o(sclk_a), .spi_miso_i(miso_a), .spi_cs_o(cs_a));

  adc_reader #(.DATA_W(DW), .CLK_DIV(1), .CONV_CYCLES(4), .OFFSET_BINARY(1'b0)) u_b (
    .clk_i(clk), .reset_i(rst), .start_i(start_b), .is_idle_o(idle_b), .data_o(data_b),
    .valid_o(valid_b), .spi_clk_o(sclk_b), .spi_miso_i(miso_b), .spi_cs_o(cs_b));

  adc_reader #(.DATA_W(DW), .CLK_DIV(3), .CONV_CYCLES(2), .OFFSET_BINARY(1'b1)) u_c (
    .clk_i(clk), .reset_i(rst), .start_i(start_c), .is_idle_o(idle_c), .data_o(data_c),
    .valid_o(valid_c), .spi_clk_o(sclk_c), .spi_miso_i(miso_c), .spi_cs_o(cs_c));

  // ADC slaves: present MSB at CS fall, advance after each SCLK falling edge.
  always begin : p_slave_a
    logic [DW-1:0] sr;
    @(negedge cs_a);
    sr = word_a;
    miso_a = sr[DW-1];
    while (cs_a === 1'b0) begin
      @(negedge sclk_a or posedge cs_a);
      if (cs_a === 1'b0) begin
        #1;
        sr = sr << 1;
        miso_a = sr[DW-1];
      end
    end
  end

  always begin : p_slave_b
    logic [DW-1:0] sr;
    @(negedge cs_b);
    sr = word_b;
    miso_b = sr[DW-1];
    while (cs_b === 1'b0) begin
      @(negedge sclk_b or posedge cs_b);
      if (cs_b === 1'b0) begin
        #1;
        sr = sr << 1;
        miso_b = sr[DW-1];
      end
    end
  end

  // This slave drives the wrong bit for the first SCLK-high cycle.
  always begin : p_slave_c
    logic [DW-1:0] sr;
    @(negedge cs_c);
    sr = word_c;
    miso_c = sr[DW-1];
    while (cs_c === 1'b0) begin
      @(posedge sclk_c or posedge cs_c);
      if (cs_c === 1'b0) begin
        miso_c = ~sr[DW-1];
        @(posedge clk);
        #1;
        miso_c = sr[DW-1];
        @(negedge sclk_c or posedge cs_c);
        #1;
        sr = sr << 1;
        miso_c = sr[DW-1];
      end
    end
  end

  function automatic logic f_cs(input int i);
    case (i) 0: return cs_a; 1: return cs_b; default: return cs_c; endcase
  endfunction
  function automatic logic f_sclk(input int i);
    case (i) 0: return sclk_a; 1: return sclk_b; default: return sclk_c; endcase
  endfunction
  function automatic logic f_valid(input int i);
    case (i) 0: return valid_a; 1: return valid_b; default: return valid_c; endcase
  endfunction
  function automatic logic f_idle(input int i);
    case (i) 0: return idle_a; 1: return idle_b; default: return idle_c; endcase
  endfunction
  function automatic logic [DW-1:0] f_data(input int i);
    case (i) 0: return data_a; 1: return data_b; default: return data_c; endcase
  endfunction
  function automatic int f_div(input int i);
    return (i == 2) ? 3 : 1;
  endfunction
  function automatic int f_conv(input int i);
    return (i == 2) ? 2 : 4;
  endfunction
  function automatic int f_off(input int i);
    return (i == 1) ? 0 : 1;
  endfunction

  task automatic set_start(input int i, input logic v);
    case (i) 0: start_a = v; 1: start_b = v; default: start_c = v; endcase
  endtask
  task automatic set_word(input int i, input logic [DW-1:0] w);
    case (i) 0: word_a = w; 1: word_b = w; default: word_c = w; endcase
  endtask

  // Reference: offset-binary code minus half scale, as a DW-bit signed value.
  function automatic logic [DW-1:0] model(input int i, input logic [DW-1:0] w);
    int v;
    if (f_off(i) == 0) return w;
    v = int'(w) - (1 << (DW - 1));
    return v[DW-1:0];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called #1 after a clock edge; returns #1 after a clock edge with start low.
  task automatic do_read(input int i, input logic [DW-1:0] w, input int hold, input string tag);
    int lat, n, first_cs, first_rise, rises, highs, vcount, vedge;
    logic prev;
    logic [DW-1:0] got;
    lat = 1 + f_conv(i) + 2 * DW * f_div(i);
    n = (hold > lat + 3) ? hold : lat + 3;
    set_word(i, w);
    set_start(i, 1'b1);
    first_cs = -1; first_rise = -1; rises = 0; highs = 0;
    vcount = 0; vedge = -1; prev = 1'b0; got = '0;
    for (int e = 0; e < n; e++) begin
      @(posedge clk);
      #1;
      if (!f_cs(i) && first_cs < 0) first_cs = e;
      if (f_sclk(i)) begin
        highs++;
        if (!prev) begin
          rises++;
          if (first_rise < 0) first_rise = e;
        end
      end
      prev = f_sclk(i);
      if (f_valid(i)) begin
        vcount++;
        if (vedge < 0) begin
          vedge = e;
          got = f_data(i);
        end
      end
    end
    check({tag, " valid_edge"}, vedge, lat);
    check({tag, " data"}, 32'(got), 32'(model(i, w)));
    check({tag, " valid_count"}, vcount, 1);
    check({tag, " sclk_rises"}, rises, DW);
    check({tag, " sclk_high_cycles"}, highs, DW * f_div(i));
    check({tag, " cs_to_sclk"}, first_rise - first_cs, f_conv(i));
    check({tag, " idle_while_held"}, 32'(f_idle(i)), 0);
    check({tag, " cs_after"}, 32'(f_cs(i)), 1);
    set_start(i, 1'b0);
    @(posedge clk);
    #1;
    check({tag, " idle_after_drop"}, 32'(f_idle(i)), 1);
    check({tag, " data_hold"}, 32'(f_data(i)), 32'(model(i, w)));
  endtask

  initial begin : p_main
    logic [DW-1:0] w;
    int rises;
    logic prev;

    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rst%0d cs", i), 32'(f_cs(i)), 1);
      check($sformatf("rst%0d sclk", i), 32'(f_sclk(i)), 0);
      check($sformatf("rst%0d valid", i), 32'(f_valid(i)), 0);
      check($sformatf("rst%0d data", i), 32'(f_data(i)), 0);
      check($sformatf("rst%0d idle", i), 32'(f_idle(i)), 1);
    end
    #2 rst = 1'b0;
    @(posedge clk);
    #1;

    do_read(0, 16'hC000, 0, "a_c000");
    do_read(0, 16'h0000, 0, "a_0000");
    do_read(0, 16'h8000, 0, "a_8000");
    do_read(0, 16'hFFFF, 0, "a_ffff");
    do_read(0, 16'hAAAA, 0, "a_aaaa");
    for (int k = 0; k < DW; k += 5) begin
      w = 16'(1 << k);
      do_read(0, w, 0, $sformatf("a_walk%0d", k));
    end
    do_read(0, 16'h5A3C, 200, "a_hold200");
    do_read(1, 16'hC000, 0, "b_c000");
    do_read(2, 16'hC000, 0, "c_c000");
    do_read(2, 16'h2B71, 0, "c_2b71");

    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 3; i++) begin
        w = 16'($urandom);
        do_read(i, w, 0, $sformatf("rnd%0d_%0d", i, r));
      end
    end

    do_read(0, 16'h1234, 0, "a_pre_reset");
    set_word(0, 16'h6E5D);
    set_start(0, 1'b1);
    rises = 0;
    prev = 1'b0;
    for (int e = 0; e < 200 && !(rises == 7 && !sclk_a); e++) begin
      @(posedge clk);
      #1;
      if (sclk_a && !prev) rises++;
      prev = sclk_a;
    end
    check("mid_reset rises", rises, 7);
    #2 rst = 1'b1;
    #1;
    check("mid_reset cs", 32'(cs_a), 1);
    check("mid_reset sclk", 32'(sclk_a), 0);
    check("mid_reset valid", 32'(valid_a), 0);
    check("mid_reset data", 32'(data_a), 0);
    check("mid_reset idle", 32'(idle_a), 1);
    set_start(0, 1'b0);
    @(posedge clk);
    #3 rst = 1'b0;
    rises = 0;
    for (int e = 0; e < 10; e++) begin
      @(posedge clk);
      #1;
      if (valid_a) rises++;
    end
    check("post_reset no_valid", rises, 0);
    check("post_reset data", 32'(data_a), 0);
    do_read(0, 16'h6E5D, 0, "a_after_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : p_watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
